// File: rtl/fixed_softmax_max_sub.sv
// Softmax max-subtraction stage: buffers one vector, tracks its signed maximum, then replays
// max - x_i left-aligned to the exponential stage's fixed-point input format.
module fixed_softmax_max_sub #(
   parameter int DATA_IN_0_PRECISION_0  = 16,
   parameter int DATA_IN_0_PRECISION_1  = 8,
   parameter int DATA_OUT_0_PRECISION_0 = 32,
   parameter int DATA_OUT_0_PRECISION_1 = 16,
   parameter int BLOCK_SIZE             = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
   input  logic                              data_in_0_valid,
   output logic                              data_in_0_ready,
   output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
   output logic                              data_out_0_valid,
   input  logic                              data_out_0_ready,
   output logic                              data_out_0_last
);

   localparam int InW   = DATA_IN_0_PRECISION_0;
   localparam int OutW  = DATA_OUT_0_PRECISION_0;
   localparam int Shift = DATA_OUT_0_PRECISION_1 - DATA_IN_0_PRECISION_1;
   localparam int DiffW = InW + 1;
   localparam int WideW = DiffW + Shift;
   localparam int ExtW  = (WideW > OutW) ? WideW : OutW;
   localparam int CntW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BLOCK_SIZE - 1);

   typedef enum logic {StFill, StDrain} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
   logic signed [InW-1:0]   max_q, max_d, new_max, din;
   logic signed [InW-1:0]   mem_q [BLOCK_SIZE];
   logic [OutW-1:0]         out_q, out_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    in_hs, out_hs, cnt_last;

   // Difference is taken one bit wider so max - min of the full signed range cannot wrap.
   function automatic logic [OutW-1:0] scale(input logic signed [InW-1:0] mx,
                                             input logic signed [InW-1:0] x);
      logic [DiffW-1:0] diff;
      logic [ExtW-1:0]  wide;
      diff = {mx[InW-1], mx} - {x[InW-1], x};
      wide = ExtW'(diff) << Shift;
      if (wide > ExtW'({OutW{1'b1}})) return '1;
      return wide[OutW-1:0];
   endfunction

   assign din             = $signed(data_in_0);
   assign data_in_0_ready = (state_q == StFill);
   assign in_hs           = data_in_0_valid & data_in_0_ready;
   assign out_hs          = valid_q & data_out_0_ready;
   assign cnt_last        = (cnt_q == CntMax);
   assign cnt_inc         = cnt_q + 1'b1;
   assign new_max         = ((cnt_q == '0) || (din > max_q)) ? din : max_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      out_d   = out_q;
      valid_d = valid_q;
      last_d  = last_q;
      unique case (state_q)
         StFill: begin
            if (in_hs) begin
               max_d = new_max;
               if (cnt_last) begin
                  // Element 0 is already buffered, so the first output can load at this edge.
                  cnt_d   = '0;
                  state_d = StDrain;
                  valid_d = 1'b1;
                  last_d  = 1'b0;
                  out_d   = scale(new_max, mem_q[0]);
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StDrain: begin
            if (out_hs) begin
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = StFill;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  cnt_d  = cnt_inc;
                  out_d  = scale(max_q, mem_q[cnt_inc]);
                  last_d = (cnt_inc == CntMax);
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFill;
         cnt_q   <= '0;
         max_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // Buffer contents are don't-care after reset, so it carries no reset.
   always_ff @(posedge clk) begin
      if (in_hs) mem_q[cnt_q] <= din;
   end

   assign data_out_0       = out_q;
   assign data_out_0_valid = valid_q;
   assign data_out_0_last  = last_q;

endmodule
